dl_skid_buf: RTL and testbench

//   Two-entry valid/ready skid buffer. It sits directly upstream of a pipeline

---
 rtl/dl_pkg.sv | 12 +
 rtl/dl_skid_buf_if.sv | 27 ++
 rtl/dl_skid_buf_ctrl.sv | 78 +++++++
 rtl/dl_skid_buf.sv | 50 +++++
 tb/tb_dl_skid_buf.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/dl_pkg.sv
// Shared types for the dl skid buffer: FSM state encoding and default data width.
package dl_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  localparam int DEFAULT_NUM_BITS = 32;

endpackage

// File: rtl/dl_skid_buf_if.sv
// Valid/ready bundle around the skid buffer: upstream (in_*) and downstream (out_*) sides.
interface dl_skid_buf_if
  import dl_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
);

    // A beat moves on a rising edge where valid & ready are both high; a source holds
    // valid and data steady until that edge, and ready never waits on valid.
    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/dl_skid_buf_ctrl.sv
// Skid buffer control: occupancy FSM with registered in_ready/out_valid and datapath load enables.
module dl_skid_buf_ctrl
  import dl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        in_ready,
    output logic        out_valid,
    output logic        load_main,
    output logic        load_skid,
    output logic        sel_skid,
    output skid_state_e state
);

    skid_state_e next_state;
    logic        in_fire;
    logic        out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        next_state = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        sel_skid   = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (in_fire) begin
                    next_state = SKID_BUSY;
                    load_main  = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    next_state = SKID_FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    next_state = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the drain side can move
                if (out_fire) begin
                    next_state = SKID_BUSY;
                    load_main  = 1'b1;
                    sel_skid   = 1'b1;
                end
            end
            default: next_state = SKID_EMPTY;
        endcase
        // Flush drops everything, including a beat accepted on the same edge
        if (flush) begin
            next_state = SKID_EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            sel_skid   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != SKID_FULL);
            out_valid <= (next_state != SKID_EMPTY);
        end
    end

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer: main register drives out_data, skid register absorbs overflow.
module dl_skid_buf
  import dl_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    dl_skid_buf_if.slave       bus,
    output skid_state_e        dbg_state
);

    logic                in_ready;
    logic                out_valid;
    logic                load_main;
    logic                load_skid;
    logic                sel_skid;
    logic [NUM_BITS-1:0] main_q;
    logic [NUM_BITS-1:0] skid_q;

    dl_skid_buf_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_main (load_main),
        .load_skid (load_skid),
        .sel_skid  (sel_skid),
        .state     (dbg_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_skid) skid_q <= bus.in_data;
            if (load_main) main_q <= sel_skid ? skid_q : bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;

endmodule

// File: tb/tb_dl_skid_buf.sv
// Bench for dl_skid_buf: directed scenarios plus random traffic against a queue-based model.
module tb_dl_skid_buf;
  import dl_pkg::*;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  logic        flush;
  skid_state_e dbg_state;

  dl_skid_buf_if #(.NUM_BITS(W)) ifc ();

  dl_skid_buf #(.NUM_BITS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int dut_acc  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    ifc.in_valid  = v;
    ifc.in_data   = d;
    ifc.out_ready = r;
  endtask

  // Buffer is a FIFO of depth 2: accept when fewer than 2 held, offer the oldest
  task automatic check_outputs();
    skid_state_e es;
    es = (exp_q.size() == 0) ? SKID_EMPTY : (exp_q.size() == 1) ? SKID_BUSY : SKID_FULL;
    chk("in_ready", 64'(ifc.in_ready), 64'(exp_q.size() < 2));
    chk("out_valid", 64'(ifc.out_valid), 64'(exp_q.size() > 0));
    chk("state", 64'(dbg_state), 64'(es));
    if (exp_q.size() > 0) chk("out_data", 64'(ifc.out_data), 64'(exp_q[0]));
  endtask

  // scoreboard step: model the coming edge from current inputs, then compare after it
  task automatic tick();
    logic         mi, mo, hold, r, f;
    logic [W-1:0] held;
    r    = rst;
    f    = flush;
    mi   = ifc.in_valid && (exp_q.size() < 2);
    mo   = ifc.out_ready && (exp_q.size() > 0);
    hold = (exp_q.size() > 0) && !ifc.out_ready;
    held = ifc.out_data;
    if (ifc.in_valid && ifc.in_ready) dut_acc++;
    if (r || f) begin
      exp_q.delete();
    end else begin
      if (mo) begin
        out_log.push_back(ifc.out_data);
        void'(exp_q.pop_front());
      end
      if (mi) exp_q.push_back(ifc.in_data);
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (hold && !r && !f) chk("stall_hold", 64'(ifc.out_data), 64'(held));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;

    // 1. reset
    do_reset();
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_data", 64'(ifc.out_data), 64'd0);

    // 2. pass-through
    dut_acc = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      tick();
      chk("pt_data", 64'(ifc.out_data), 64'(i));
    end
    chk("pt_beats", 64'(dut_acc), 64'd8);
    drive(1'b0, '0, 1'b1);
    tick();

    // 3. backpressure
    do_reset();
    out_log.delete();
    drive(1'b1, 32'hA, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0); tick();
    chk("bp_full_ready", 64'(ifc.in_ready), 64'd0);
    drive(1'b1, 32'hC, 1'b0); tick();
    chk("bp_held_data", 64'(ifc.out_data), 64'hA);
    drive(1'b1, 32'hC, 1'b1); tick();
    tick();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      chk("bp_seq0", 64'(out_log[0]), 64'hA);
      chk("bp_seq1", 64'(out_log[1]), 64'hB);
      chk("bp_seq2", 64'(out_log[2]), 64'hC);
    end

    // 4. simultaneous in/out fire while BUSY
    do_reset();
    drive(1'b1, 32'h5, 1'b0); tick();
    drive(1'b1, 32'h6, 1'b1); tick();
    chk("sim_data", 64'(ifc.out_data), 64'h6);
    chk("sim_state", 64'(dbg_state), 64'(SKID_BUSY));
    drive(1'b0, '0, 1'b1); tick();

    // 5. flush while FULL with a same-cycle offer
    do_reset();
    drive(1'b1, 32'hA, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0); tick();
    flush = 1'b0;
    chk("fl_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("fl_in_ready", 64'(ifc.in_ready), 64'd1);
    out_log.delete();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("fl_no_leak", 64'(out_log.size()), 64'd0);
    drive(1'b1, 32'hD, 1'b1); tick();
    chk("fl_next_data", 64'(ifc.out_data), 64'hD);
    drive(1'b0, '0, 1'b1); tick();

    // 6. random traffic with rare flushes
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 199) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("rnd_drained", 64'(ifc.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
